mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one fixed-latency, single-port unified memory between instruction fetch (IF) and data access (DM) for the multicycle CPU variant.
- Arbitrates between the two requesters, sequences each access through a latency counter, and returns data with a one-cycle ack pulse.
- Drives stall requests back to the CPU so the PC and register file hold while an access is outstanding.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- LATENCY, 4, cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  DATA_W  fetched instruction.
- dm_req  in  1  data request; held until dm_ack.
- dm_wr  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  DATA_W  read data; zero after a write.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_wr  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after mem_en.
- stall_if  out  1  combinational: if_req & ~if_ack.
- stall_dm  out  1  combinational: dm_req & ~dm_ack.

Behaviour:
- Reset (async, rst=1): state=IDLE; all registered outputs 0; last_owner=DM, so fetch wins the first tie.
- FSM states: IDLE, ISSUE, WAIT, RESP. All mem_* outputs and ack/rdata outputs are registered.
- IDLE:
  - Only dm_req: grant DM.
  - Only if_req: grant IF.
  - Both: grant the requester that is not last_owner.
  - On grant: latch owner, address, wr and wdata; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly 1 cycle): mem_en=1, with mem_wr/mem_addr/mem_wdata from the latched values. Load cnt=LATENCY-1; go to WAIT.
- WAIT:
  - cnt>0: decrement.
  - cnt==0: capture mem_rdata (0 for writes), update last_owner=owner, go to RESP.
- RESP (1 cycle): pulse the owner's ack; the owner's rdata holds the captured value until the next ack to that owner. Always return to IDLE.
- Latency and throughput: request first high in cycle 0 gives ack in cycle LATENCY+2. Back-to-back transactions are spaced LATENCY+3 cycles apart.
- Requester still high in its RESP cycle: treated as a new request and re-arbitrated in the following IDLE.
- Request withdrawn mid-transaction: the access still completes and the ack still pulses; the requester ignores it. No abort path exists.
- Inputs changing after grant: ignored, because values are latched in IDLE.
- The non-granted requester sees its stall_* held high throughout.
- Reset mid-transaction: access abandoned; no ack is issued; mem_en stays 0 from reset assertion onward.
- Never asserted: if_ack and dm_ack in the same cycle, or mem_en for two consecutive cycles.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, two extra output ports are added:
  - if_wait_cnt [31:0]: counts cycles where stall_if=1.
  - dm_wait_cnt [31:0]: counts cycles where stall_dm=1.
  - Both saturate at 32'hFFFF_FFFF and are cleared by rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (cpu_pkg):
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP).
  - owner_t constants OWN_IF=1'b0, OWN_DM=1'b1.
  - Default LATENCY constant.
- One natural sub-module: arb_rr2, a combinational 2-way round-robin picker. Inputs are req_if, req_dm and last_owner; outputs are gnt_valid and gnt_owner.

Test Plan:
- Single fetch, LATENCY=4, mem returns 16'hA5A5:
  - if_req=1 with if_addr=16'h0010 at cycle 0.
  - mem_en=1 and mem_addr=16'h0010 in cycle 1.
  - if_ack=1 and if_rdata=16'hA5A5 in cycle 6 only.
- Data write: dm_req=1, dm_wr=1, dm_addr=16'h0200, dm_wdata=16'h1234 -> one mem_en cycle with mem_wr=1 and those values; dm_ack in cycle 6; dm_rdata=0.
- Simultaneous if_req and dm_req, both held through three transactions, from reset -> grants in order IF, DM, IF; acks at cycles 6, 13, 20.
- Reset mid-transaction: assert rst in cycle 3 of a fetch -> no if_ack; all outputs 0 immediately; fresh fetch after release acks LATENCY+2 cycles later.
- LATENCY=1: fetch with mem_rdata=16'h00FF -> if_ack in cycle 3 with 16'h00FF; stall_if=1 during cycles 0-2.
- With MEM_ARB_PERF_EN defined: a DM access blocked behind one IF access -> dm_wait_cnt increments every cycle until dm_ack.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the multicycle CPU memory arbiter: FSM states, owner encoding, default latency.
// Optional build macro used by mem_arbiter: MEM_ARB_PERF_EN.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef logic owner_t;

    localparam owner_t OWN_IF = 1'b0;
    localparam owner_t OWN_DM = 1'b1;

    localparam int DEFAULT_LATENCY = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker between instruction fetch and data access.
// On a tie the requester that did not own the previous transaction wins.
module arb_rr2
    import cpu_pkg::*;
(
    input  logic   req_if,
    input  logic   req_dm,
    input  owner_t last_owner,
    output logic   gnt_valid,
    output owner_t gnt_owner
);

    // Pick the winner for this cycle.
    always_comb begin
        gnt_valid = req_if | req_dm;
        if (req_if && req_dm) begin
            gnt_owner = ~last_owner;
        end else if (req_dm) begin
            gnt_owner = OWN_DM;
        end else begin
            gnt_owner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF and DM accesses onto one fixed-latency single-port memory.
// Build macro MEM_ARB_PERF_EN adds saturating stall-cycle counters (if_wait_cnt, dm_wait_cnt).
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_dm
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       if_wait_cnt,
    output logic [31:0]       dm_wait_cnt
`endif
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    arb_state_t        state_r;
    owner_t            owner_r;
    owner_t            last_owner_r;
    logic [3:0]        cnt_r;
    logic              gnt_valid_s;
    owner_t            gnt_owner_s;
    logic              gnt_wr_s;
    logic [ADDR_W-1:0] gnt_addr_s;
    logic [DATA_W-1:0] gnt_wdata_s;
    logic [DATA_W-1:0] capture_s;

    arb_rr2 u_rr (
        .req_if     (if_req),
        .req_dm     (dm_req),
        .last_owner (last_owner_r),
        .gnt_valid  (gnt_valid_s),
        .gnt_owner  (gnt_owner_s)
    );

    // Select the request fields of the winning requester; fetches never write.
    always_comb begin
        if (gnt_owner_s == OWN_DM) begin
            gnt_wr_s    = dm_wr;
            gnt_addr_s  = dm_addr;
            gnt_wdata_s = dm_wdata;
        end else begin
            gnt_wr_s    = 1'b0;
            gnt_addr_s  = if_addr;
            gnt_wdata_s = {DATA_W{1'b0}};
        end
    end

    // mem_wr holds the latched direction for the whole transaction, so writes return zero.
    always_comb begin
        if (mem_wr) begin
            capture_s = {DATA_W{1'b0}};
        end else begin
            capture_s = mem_rdata;
        end
    end

    // Transaction sequencer: grant, issue strobe, latency countdown, ack pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_r      <= OWN_IF;
            last_owner_r <= OWN_DM;
            cnt_r        <= 4'd0;
            mem_en       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= {DATA_W{1'b0}};
            if_ack       <= 1'b0;
            dm_ack       <= 1'b0;
            if_rdata     <= {DATA_W{1'b0}};
            dm_rdata     <= {DATA_W{1'b0}};
        end else begin
            mem_en <= 1'b0;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (gnt_valid_s) begin
                        owner_r   <= gnt_owner_s;
                        mem_en    <= 1'b1;
                        mem_wr    <= gnt_wr_s;
                        mem_addr  <= gnt_addr_s;
                        mem_wdata <= gnt_wdata_s;
                        state_r   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_r   <= CNT_LOAD;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        if (owner_r == OWN_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= capture_s;
                        end else begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= capture_s;
                        end
                        last_owner_r <= owner_r;
                        state_r      <= RESP;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign stall_if = if_req & ~if_ack;
    assign stall_dm = dm_req & ~dm_ack;

`ifdef MEM_ARB_PERF_EN
    // Saturating count of cycles each requester spends stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_wait_cnt <= 32'd0;
            dm_wait_cnt <= 32'd0;
        end else begin
            if (stall_if && (if_wait_cnt != 32'hFFFF_FFFF)) begin
                if_wait_cnt <= if_wait_cnt + 32'd1;
            end
            if (stall_dm && (dm_wait_cnt != 32'hFFFF_FFFF)) begin
                dm_wait_cnt <= dm_wait_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
